// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
//
// Purpose: divides a DW-bit (DW = 2N+1) unsigned dividend by an N-bit unsigned
// divisor using the restoring algorithm. It sits beside the shift-add
// multiplier so that a product can be divided back by one of its factors.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   i_start      request, sampled only while idle
//   i_dividend   DW-bit numerator, latched on accept
//   i_divisor    N-bit denominator, latched on accept
//   o_quotient   DW-bit quotient, held from one completion to the next
//   o_remainder  N-bit remainder, held from one completion to the next
//   o_busy       high from the accept edge until the edge that leaves DONE
//   o_done       one-cycle completion pulse
//   o_dz         divide-by-zero flag for the last operation
module seq_divider #(
    parameter int N  = 4,
    parameter int DW = 2 * N + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [N-1:0]  i_divisor,
    output logic [DW-1:0] o_quotient,
    output logic [N-1:0]  o_remainder,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_dz
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_q;
    logic [N-1:0]  r_d;
    logic [N:0]    r_r;
    logic [CW-1:0] r_cnt;
    logic          r_dz;

    logic [N:0]    w_r_shift;
    logic          w_ge;
    logic [N:0]    w_r_next;
    logic [DW-1:0] w_q_next;
    logic          w_unused;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits and record the quotient bit.
    // The remainder is always below the divisor before the shift, so its top
    // bit is never needed as a source for the next shift.
    assign w_r_shift = {r_r[N-1:0], r_q[DW-1]};
    assign w_ge      = (w_r_shift >= {1'b0, r_d});
    assign w_r_next  = w_ge ? (w_r_shift - {1'b0, r_d}) : w_r_shift;
    assign w_q_next  = {r_q[DW-2:0], w_ge};
    assign w_unused  = r_r[N];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_dz        <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_dz        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_q     <= i_dividend;
                        r_d     <= i_divisor;
                        r_r     <= '0;
                        r_cnt   <= CW'(DW);
                        r_dz    <= (i_divisor == '0);
                        o_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_dz) begin
                        // A zero divisor spends a single cycle here so that
                        // its done pulse lands one cycle after accept through
                        // the same registered completion path.
                        o_quotient  <= '1;
                        o_remainder <= r_q[N-1:0];
                        o_dz        <= 1'b1;
                        o_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_q   <= w_q_next;
                        r_r   <= w_r_next;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            o_quotient  <= w_q_next;
                            o_remainder <= w_r_next[N-1:0];
                            o_dz        <= 1'b0;
                            o_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
